// File: rtl/uart_report_sched.sv
// Arbitrates time-report and alarm requests and streams the chosen ASCII message
// byte by byte to a UART transmitter, with an acknowledge timeout per byte.
module uart_report_sched #(
   parameter int ACK_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_time,
   input  logic        req_alarm,
   input  logic [7:0]  day,
   input  logic [7:0]  month,
   input  logic [15:0] year,
   input  logic [7:0]  hour,
   input  logic [7:0]  min,
   input  logic [7:0]  sec,
   input  logic [7:0]  alarm_hour,
   input  logic [7:0]  alarm_min,
   input  logic        tx_busy,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   output logic        busy,
   output logic        grant,
   output logic        done,
   output logic        err
);
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_ACK, S_WAIT_DONE} state_t;

   state_t      r_state, w_state_next;
   logic        r_pend_time, r_pend_alarm;
   logic [4:0]  r_idx, w_idx_next;
   logic [3:0]  r_cnt, w_cnt_next;
   logic        r_tx_start, w_tx_start_next;
   logic [7:0]  r_tx_data, w_tx_data_next;
   logic        r_grant, w_grant_next;
   logic        r_last, w_last_next;
   logic        r_done, w_done_next;
   logic        r_err, w_err_next;
   logic        w_snap, w_clr_time, w_clr_alarm, w_pick_alarm;
   logic [4:0]  w_last_idx;
   logic [7:0]  w_char;

   logic [7:0]  r_day, r_month, r_hour, r_min, r_sec, r_ahour, r_amin;
   logic [15:0] r_year;

   function automatic logic [7:0] bcd_char(input logic [3:0] d);
      return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
   endfunction

   assign tx_start = r_tx_start;
   assign tx_data  = r_tx_data;
   assign busy     = (r_state != S_IDLE);
   assign grant    = r_grant;
   assign done     = r_done;
   assign err      = r_err;

   assign w_last_idx = r_grant ? 5'd12 : 5'd20;

   always_comb begin
      w_char = 8'h00;
      if (r_grant) begin
         case (r_idx)
            5'd0:  w_char = 8'h41;
            5'd1:  w_char = 8'h4C;
            5'd2:  w_char = 8'h41;
            5'd3:  w_char = 8'h52;
            5'd4:  w_char = 8'h4D;
            5'd5:  w_char = 8'h20;
            5'd6:  w_char = bcd_char(r_ahour[7:4]);
            5'd7:  w_char = bcd_char(r_ahour[3:0]);
            5'd8:  w_char = 8'h3A;
            5'd9:  w_char = bcd_char(r_amin[7:4]);
            5'd10: w_char = bcd_char(r_amin[3:0]);
            5'd11: w_char = 8'h0D;
            5'd12: w_char = 8'h0A;
            default: w_char = 8'h00;
         endcase
      end else begin
         case (r_idx)
            5'd0:  w_char = bcd_char(r_day[7:4]);
            5'd1:  w_char = bcd_char(r_day[3:0]);
            5'd2:  w_char = 8'h2E;
            5'd3:  w_char = bcd_char(r_month[7:4]);
            5'd4:  w_char = bcd_char(r_month[3:0]);
            5'd5:  w_char = 8'h2E;
            5'd6:  w_char = bcd_char(r_year[15:12]);
            5'd7:  w_char = bcd_char(r_year[11:8]);
            5'd8:  w_char = bcd_char(r_year[7:4]);
            5'd9:  w_char = bcd_char(r_year[3:0]);
            5'd10: w_char = 8'h20;
            5'd11: w_char = bcd_char(r_hour[7:4]);
            5'd12: w_char = bcd_char(r_hour[3:0]);
            5'd13: w_char = 8'h3A;
            5'd14: w_char = bcd_char(r_min[7:4]);
            5'd15: w_char = bcd_char(r_min[3:0]);
            5'd16: w_char = 8'h3A;
            5'd17: w_char = bcd_char(r_sec[7:4]);
            5'd18: w_char = bcd_char(r_sec[3:0]);
            5'd19: w_char = 8'h0D;
            5'd20: w_char = 8'h0A;
            default: w_char = 8'h00;
         endcase
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_idx_next      = r_idx;
      w_cnt_next      = r_cnt;
      w_tx_start_next = 1'b0;
      w_tx_data_next  = r_tx_data;
      w_grant_next    = r_grant;
      w_last_next     = r_last;
      w_done_next     = 1'b0;
      w_err_next      = 1'b0;
      w_snap          = 1'b0;
      w_clr_time      = 1'b0;
      w_clr_alarm     = 1'b0;
      // r_last: 0 = time served last, so a tie goes to alarm
      w_pick_alarm    = r_pend_alarm & (~r_pend_time | ~r_last);
      case (r_state)
         S_IDLE: begin
            if (r_pend_time || r_pend_alarm) begin
               w_grant_next = w_pick_alarm;
               w_last_next  = w_pick_alarm;
               w_clr_alarm  = w_pick_alarm;
               w_clr_time   = ~w_pick_alarm;
               w_snap       = 1'b1;
               w_idx_next   = 5'd0;
               w_state_next = S_SEND;
            end
         end
         S_SEND: begin
            w_tx_start_next = 1'b1;
            w_tx_data_next  = w_char;
            w_cnt_next      = 4'd0;
            w_state_next    = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (tx_busy) begin
               w_state_next = S_WAIT_DONE;
            end else if (r_cnt == 4'(ACK_TIMEOUT - 1)) begin
               w_err_next   = 1'b1;
               w_state_next = S_IDLE;
            end else begin
               w_cnt_next = r_cnt + 4'd1;
            end
         end
         S_WAIT_DONE: begin
            if (!tx_busy) begin
               if (r_idx == w_last_idx) begin
                  w_done_next  = 1'b1;
                  w_state_next = S_IDLE;
               end else begin
                  w_idx_next   = r_idx + 5'd1;
                  w_state_next = S_SEND;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_pend_time  <= 1'b0;
         r_pend_alarm <= 1'b0;
         r_idx        <= 5'd0;
         r_cnt        <= 4'd0;
         r_tx_start   <= 1'b0;
         r_tx_data    <= 8'h00;
         r_grant      <= 1'b0;
         r_last       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_pend_time  <= req_time | (r_pend_time & ~w_clr_time);
         r_pend_alarm <= req_alarm | (r_pend_alarm & ~w_clr_alarm);
         r_idx        <= w_idx_next;
         r_cnt        <= w_cnt_next;
         r_tx_start   <= w_tx_start_next;
         r_tx_data    <= w_tx_data_next;
         r_grant      <= w_grant_next;
         r_last       <= w_last_next;
         r_done       <= w_done_next;
         r_err        <= w_err_next;
      end
   end

   always_ff @(posedge clk) begin
      if (w_snap) begin
         r_day   <= day;
         r_month <= month;
         r_year  <= year;
         r_hour  <= hour;
         r_min   <= min;
         r_sec   <= sec;
         r_ahour <= alarm_hour;
         r_amin  <= alarm_min;
      end
   end
endmodule

// File: tb/tb_uart_report_sched.sv
// Directed bench: a UART model acknowledges each byte; received bytes and
// done/err pulses are compared against hand-written expected messages.
module tb_uart_report_sched;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_time, req_alarm;
   logic [7:0]  day, month, hour, min, sec, alarm_hour, alarm_min;
   logic [15:0] year;
   logic        tx_busy;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        busy, grant, done, err;

   int          n_chk = 0;
   int          n_pass = 0;
   int          n_done = 0;
   int          n_err = 0;
   int          n_start_rst = 0;
   int          busy_cnt = 0;
   logic        uart_dead = 1'b0;
   logic [7:0]  rx_q[$];

   always #5 clk = ~clk;

   uart_report_sched #(.ACK_TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .req_time(req_time), .req_alarm(req_alarm),
      .day(day), .month(month), .year(year), .hour(hour), .min(min), .sec(sec),
      .alarm_hour(alarm_hour), .alarm_min(alarm_min), .tx_busy(tx_busy),
      .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .grant(grant),
      .done(done), .err(err)
   );

   // UART model: busy rises one cycle after tx_start and stays high 20 cycles
   assign tx_busy = (busy_cnt != 0);

   always @(posedge clk) begin
      if (tx_start) begin
         rx_q.push_back(tx_data);
         if (!reset) n_start_rst <= n_start_rst + 1;
      end
      if (done) n_done <= n_done + 1;
      if (err)  n_err  <= n_err + 1;
      if (tx_start && !uart_dead) busy_cnt <= 20;
      else if (busy_cnt != 0)     busy_cnt <= busy_cnt - 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // returns at the negedge following the sampling edge k
   task automatic pulse_req(input logic t, input logic a);
      @(negedge clk);
      req_time  = t;
      req_alarm = a;
      @(negedge clk);
      req_time  = 1'b0;
      req_alarm = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int target, input int budget);
      int c = 0;
      while (n_done < target && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk(tag, n_done, target);
   endtask

   task automatic wait_bytes(input string tag, input int target, input int budget);
      int c = 0;
      while (rx_q.size() < target && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk(tag, rx_q.size(), target);
   endtask

   task automatic chk_msg(input string tag, input int base, input string body);
      int n;
      logic [31:0] got;
      logic [7:0]  e8;
      n = body.len();
      chk({tag, "_len"}, (rx_q.size() >= base + n + 2) ? 1 : 0, 1);
      for (int i = 0; i < n + 2; i++) begin
         got = (base + i < rx_q.size()) ? {24'h0, rx_q[base + i]} : 32'hFFFF_FFFF;
         if (i < n)       e8 = body[i];
         else if (i == n) e8 = 8'h0D;
         else             e8 = 8'h0A;
         chk($sformatf("%s_b%0d", tag, i), got, {24'h0, e8});
      end
      $display("msg %s: %0d bytes checked from offset %0d", tag, n + 2, base);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tx_start"}, tx_start, 0);
      chk({tag, "_tx_data"},  tx_data,  0);
      chk({tag, "_busy"},     busy,     0);
      chk({tag, "_grant"},    grant,    0);
      chk({tag, "_done"},     done,     0);
      chk({tag, "_err"},      err,      0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      tick(3);
      reset = 1'b1;
   endtask

   initial begin
      int base, d0, e0;
      reset = 1'b0; req_time = 1'b1; req_alarm = 1'b1;
      day = 8'h07; month = 8'h12; year = 16'h2024;
      hour = 8'h09; min = 8'h05; sec = 8'h30;
      alarm_hour = 8'h07; alarm_min = 8'h30;

      // reset state, requests held high during reset are ignored
      tick(4);
      chk_reset_outputs("rst");
      reset = 1'b1; req_time = 1'b0; req_alarm = 1'b0;
      tick(10);
      chk("rst_ignored_busy", busy, 0);
      chk("rst_ignored_bytes", rx_q.size(), 0);

      // time report with latency check
      base = rx_q.size(); d0 = n_done;
      pulse_req(1'b1, 1'b0);
      chk("lat_k_busy", busy, 0);
      chk("lat_k_start", tx_start, 0);
      tick(1);
      chk("lat_k1_busy", busy, 1);
      chk("lat_k1_start", tx_start, 0);
      chk("lat_k1_grant", grant, 0);
      tick(1);
      chk("lat_k2_start", tx_start, 1);
      chk("lat_k2_data", tx_data, 8'h30);
      wait_done("time_done", d0 + 1, 1500);
      tick(50);
      chk_msg("time", base, "07.12.2024 09:05:30");
      chk("time_one_done", n_done, d0 + 1);
      chk("time_no_err", n_err, 0);
      chk("time_idle", busy, 0);

      // simultaneous requests right after reset: alarm first
      do_reset();
      base = rx_q.size(); d0 = n_done;
      pulse_req(1'b1, 1'b1);
      tick(1);
      chk("arb_grant_alarm", grant, 1);
      wait_done("arb_done", d0 + 2, 3000);
      tick(50);
      chk_msg("arb_alarm", base, "ALARM 07:30");
      chk_msg("arb_time", base + 13, "07.12.2024 09:05:30");
      chk("arb_two_done", n_done, d0 + 2);
      chk("arb_total_bytes", rx_q.size(), base + 34);

      // merge: 5 requests during an active message yield one extra message
      base = rx_q.size(); d0 = n_done;
      pulse_req(1'b1, 1'b0);
      wait_bytes("merge_start", base + 1, 50);
      for (int i = 0; i < 5; i++) begin
         tick(15);
         pulse_req(1'b1, 1'b0);
      end
      wait_done("merge_done", d0 + 2, 3000);
      tick(100);
      chk("merge_two_done", n_done, d0 + 2);
      chk("merge_bytes", rx_q.size(), base + 42);
      chk_msg("merge_m1", base, "07.12.2024 09:05:30");
      chk_msg("merge_m2", base + 21, "07.12.2024 09:05:30");
      chk("merge_idle", busy, 0);

      // invalid BCD digit and snapshot isolation
      hour = 8'hA3;
      base = rx_q.size(); d0 = n_done;
      pulse_req(1'b1, 1'b0);
      wait_bytes("bcd_started", base + 3, 100);
      sec = 8'h59; hour = 8'h11;
      wait_done("bcd_done", d0 + 1, 1500);
      tick(5);
      chk_msg("bcd", base, "07.12.2024 ?3:05:30");
      hour = 8'h09; sec = 8'h30;

      // acknowledge timeout
      uart_dead = 1'b1;
      base = rx_q.size(); d0 = n_done; e0 = n_err;
      pulse_req(1'b1, 1'b0);
      tick(16);
      chk("to_err_early", err, 0);
      tick(1);
      chk("to_err_pulse", err, 1);
      tick(1);
      chk("to_err_clear", err, 0);
      chk("to_busy_low", busy, 0);
      tick(20);
      chk("to_err_count", n_err, e0 + 1);
      chk("to_no_done", n_done, d0);
      chk("to_one_byte", rx_q.size(), base + 1);
      uart_dead = 1'b0;

      // reset at byte 8 of a time message
      base = rx_q.size(); d0 = n_done;
      pulse_req(1'b1, 1'b0);
      wait_bytes("mid_reach_b8", base + 9, 400);
      reset = 1'b0; req_time = 1'b1;
      tick(1);
      chk_reset_outputs("mid");
      tick(20);
      reset = 1'b1; req_time = 1'b0;
      tick(100);
      chk("mid_no_start_in_rst", n_start_rst, 0);
      chk("mid_bytes", rx_q.size(), base + 9);
      chk("mid_no_done", n_done, d0);
      chk("mid_idle", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
